// File: rtl/acc_operand_loader.sv
// -----------------------------------------------------------------------------
// acc_operand_loader
//
// Upstream feeder for the 128-bit accumulator/adder stage (acc). A narrow W-bit
// word stream is assembled into two N-bit operands: BEATS words of operand A,
// then BEATS words of operand B. Each operand arrives least-significant word
// first. The carry-in is taken with the last B word. The complete set is then
// presented to acc together with a one-cycle enable strobe. The operand outputs
// hold their value between issues, so acc always sees a coherent set while the
// next set loads.
//
// Handshake (in_valid / in_ready):
//   A word transfers on a rising clk edge where in_valid and in_ready are both
//   high. The source keeps in_data/in_cin stable until that edge. in_ready
//   depends only on reset and the FSM state, never on in_valid. in_ready is low
//   while reset is high and during the single ISSUE cycle.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   in_valid   source presents a valid word
//   in_ready   loader accepts a word this cycle
//   in_data    operand word (W bits)
//   in_cin     carry-in, sampled only on the last B beat
//   enable     one-cycle issue strobe to acc
//   data_in1   operand A to acc (N bits)
//   data_in2   operand B to acc (N bits)
//   data_cin   carry-in to acc
//   busy       set partially or fully loaded but not yet issued
//   dbg_state  current FSM state (0 LOAD_A, 1 LOAD_B, 2 ISSUE)
// -----------------------------------------------------------------------------
module acc_operand_loader #(
   parameter  int N     = 128,
   parameter  int W     = 32,
   localparam int BEATS = N / W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic         in_cin,
   output logic         enable,
   output logic [N-1:0] data_in1,
   output logic [N-1:0] data_in2,
   output logic         data_cin,
   output logic         busy,
   output logic [1:0]   dbg_state
);

   // Counter width stays at least one bit, even in the degenerate BEATS == 1 case.
   localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      ISSUE  = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [N-1:0]  stage_a;
   logic [N-1:0]  stage_b;
   logic [N-1:0]  stage_b_next;
   logic          xfer;
   logic          last_beat;

   // in_ready is decoded from reset and state only. It therefore rises in the
   // first cycle after reset deasserts, with no dependence on in_valid.
   always_comb begin
      in_ready  = !reset && (state != ISSUE);
      xfer      = in_valid && in_ready;
      last_beat = (cnt == LAST_CNT);
   end

   // The final B word is written into stage_b on the same edge that loads the
   // output registers. data_in2 must therefore take the merged value, not the
   // stale staging register.
   always_comb begin
      stage_b_next = stage_b;
      stage_b_next[W*cnt +: W] = in_data;
   end

   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= LOAD_A;
         cnt      <= '0;
         stage_a  <= '0;
         stage_b  <= '0;
         enable   <= 1'b0;
         data_in1 <= '0;
         data_in2 <= '0;
         data_cin <= 1'b0;
         busy     <= 1'b0;
      end else begin
         // enable is only ever set on the edge that enters ISSUE, so it is a
         // single-cycle pulse.
         enable <= 1'b0;
         case (state)
            LOAD_A: begin
               if (xfer) begin
                  stage_a[W*cnt +: W] <= in_data;
                  busy                <= 1'b1;
                  if (last_beat) begin
                     cnt   <= '0;
                     state <= LOAD_B;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            LOAD_B: begin
               if (xfer) begin
                  stage_b[W*cnt +: W] <= in_data;
                  if (last_beat) begin
                     // The carry-in goes straight to data_cin. It is needed on
                     // this same edge, so it needs no separate staging flop.
                     cnt      <= '0;
                     state    <= ISSUE;
                     enable   <= 1'b1;
                     data_in1 <= stage_a;
                     data_in2 <= stage_b_next;
                     data_cin <= in_cin;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            ISSUE: begin
               state <= LOAD_A;
               busy  <= 1'b0;
            end
            default: begin
               state <= LOAD_A;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_acc_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_acc_operand_loader
//
// Directed bench for acc_operand_loader. The sections are: clock/reset, driver
// tasks (send, idle, load_set), an issue monitor with an expected-operand queue,
// the linear stimulus sequence, and the final report.
// -----------------------------------------------------------------------------
module tb_acc_operand_loader;

   localparam int N     = 128;
   localparam int W     = 32;
   localparam int BEATS = N / W;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         in_cin;
   logic         enable;
   logic [N-1:0] data_in1;
   logic [N-1:0] data_in2;
   logic         data_cin;
   logic         busy;
   logic [1:0]   dbg_state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int en_count = 0;
   int en_cyc = 0;
   int prev_en_cyc = 0;
   logic prev_enable = 1'b0;

   // Scoreboard entry: {cin, B, A}
   logic [2*N:0] exp_q[$];

   acc_operand_loader #(.N(N), .W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_cin    (in_cin),
      .enable    (enable),
      .data_in1  (data_in1),
      .data_in2  (data_in2),
      .data_cin  (data_cin),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [2*N:0] obs, input logic [2*N:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue monitor: every enable pulse must match the oldest expected set, and
   // enable may never stay high two cycles in a row.
   always @(negedge clk) begin
      if (enable === 1'b1) begin
         en_count++;
         prev_en_cyc = en_cyc;
         en_cyc = cyc;
         chk("enable_single_cycle", {{(2*N){1'b0}}, prev_enable}, '0);
         chk("issue_expected", {{(2*N){1'b0}}, exp_q.size() != 0}, 1);
         if (exp_q.size() != 0)
            chk("issue_operands", {data_cin, data_in2, data_in1}, exp_q.pop_front());
      end
      prev_enable = enable;
   end

   // ---------------- drivers ----------------
   // Present one word. Called just after a rising edge. Returns just after the
   // edge on which the word transferred, with the cycle it was accepted in and
   // how many cycles it waited.
   task automatic send(input logic [W-1:0] d, input logic c, output int acc_cyc, output int stalls);
      in_valid = 1'b1;
      in_data  = d;
      in_cin   = c;
      stalls   = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && stalls < 40) begin
         stalls++;
         @(negedge clk);
      end
      chk("in_ready_wait", {{(2*N){1'b0}}, in_ready}, 1);
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_cin   = 1'b0;
   endtask

   // Hold in_valid low for n cycles. The partial set must stay pending.
   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(negedge clk);
         chk("gap_busy", {{(2*N){1'b0}}, busy}, 1);
         @(posedge clk);
         #1;
      end
   endtask

   // Stream a full operand set without gaps. in_cin carries the inverse of the
   // wanted carry on every beat but the last, so only the last beat counts.
   task automatic load_set(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                           input logic hold_chk, input logic [2*N:0] hold_v,
                           output int first_cyc, output int first_stalls);
      int acc;
      int st;
      first_cyc = 0;
      first_stalls = 0;
      exp_q.push_back({c, b, a});
      for (int i = 0; i < 2*BEATS; i++) begin
         if (i < BEATS)
            send(a[W*i +: W], ~c, acc, st);
         else
            send(b[W*(i-BEATS) +: W], (i == 2*BEATS-1) ? c : ~c, acc, st);
         if (i == 0) begin
            first_cyc = acc;
            first_stalls = st;
         end
         if (hold_chk && i < 2*BEATS-1)
            chk("operands_held", {data_cin, data_in2, data_in1}, hold_v);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t0;
      int st;
      int acc;
      int saved_en;
      logic [N:0] sum;
      logic [2*N:0] set1;

      // Reset with in_valid high: nothing may be accepted.
      reset    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'h1234_5678;
      in_cin   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_enable",   {{(2*N){1'b0}}, enable}, 0);
      chk("rst_busy",     {{(2*N){1'b0}}, busy}, 0);
      chk("rst_in_ready", {{(2*N){1'b0}}, in_ready}, 0);
      chk("rst_operands", {data_cin, data_in2, data_in1}, 0);
      chk("rst_state",    {{(2*N-1){1'b0}}, dbg_state}, 0);
      reset    = 1'b0;
      in_valid = 1'b0;
      in_cin   = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", {{(2*N){1'b0}}, in_ready}, 1);
      chk("post_rst_busy",     {{(2*N){1'b0}}, busy}, 0);
      @(posedge clk);
      #1;

      // Basic load: A=AAAAAAAA, B=55555555, cin=1, continuous.
      load_set(128'hAAAAAAAA, 128'h55555555, 1'b1, 1'b0, '0, t0, st);
      @(negedge clk);
      chk("basic_enable", {{(2*N){1'b0}}, enable}, 1);
      chk("basic_busy_issue", {{(2*N){1'b0}}, busy}, 1);
      chk("basic_a", {{(N+1){1'b0}}, data_in1}, 128'hAAAAAAAA);
      sum = {1'b0, data_in1} + {1'b0, data_in2} + {{N{1'b0}}, data_cin};
      chk("basic_acc_sum", {{N{1'b0}}, sum}, 129'h1_0000_0000);
      @(negedge clk);
      chk("basic_enable_drop", {{(2*N){1'b0}}, enable}, 0);
      chk("basic_busy_after", {{(2*N){1'b0}}, busy}, 0);
      // Enable lands in the ninth cycle, counting the first beat's cycle as one.
      chk("basic_latency", en_cyc - t0, 8);
      @(posedge clk);
      #1;

      // Full width: all-ones operands, cin=0.
      load_set({N{1'b1}}, {N{1'b1}}, 1'b0, 1'b0, '0, t0, st);
      @(negedge clk);
      chk("full_enable", {{(2*N){1'b0}}, enable}, 1);
      chk("full_top_word", {{(2*N+1-W){1'b0}}, data_in1[127:96]}, 32'hFFFF_FFFF);
      chk("full_cin", {{(2*N){1'b0}}, data_cin}, 0);
      @(posedge clk);
      #1;

      // Word ordering: distinct words per slot.
      load_set(128'h44444444_33333333_22222222_11111111,
               128'h88888888_77777777_66666666_55555555, 1'b1, 1'b0, '0, t0, st);
      @(negedge clk);
      chk("order_a_top", {{(2*N+1-W){1'b0}}, data_in1[127:96]}, 32'h4444_4444);
      chk("order_b_low", {{(2*N+1-W){1'b0}}, data_in2[31:0]}, 32'h5555_5555);
      @(posedge clk);
      #1;

      // Gapped source: 3 idle cycles after A beat 1, 2 after B beat 2.
      exp_q.push_back({1'b1, 128'h55555555, 128'hAAAAAAAA});
      send(32'hAAAA_AAAA, 1'b0, t0, st);
      send(32'h0, 1'b0, acc, st);
      idle(3);
      send(32'h0, 1'b0, acc, st);
      send(32'h0, 1'b0, acc, st);
      send(32'h5555_5555, 1'b0, acc, st);
      send(32'h0, 1'b0, acc, st);
      send(32'h0, 1'b0, acc, st);
      idle(2);
      send(32'h0, 1'b1, acc, st);
      @(negedge clk);
      chk("gap_enable", {{(2*N){1'b0}}, enable}, 1);
      @(negedge clk);
      chk("gap_latency", en_cyc - t0, 13);
      @(posedge clk);
      #1;

      // Back-to-back: the second set's first word is offered during ISSUE.
      set1 = {1'b0, 128'h0F0E0D0C_0B0A0908_07060504_03020100,
                    128'hF0E0D0C0_B0A09080_70605040_30201000};
      load_set(set1[N-1:0], set1[2*N-1:N], set1[2*N], 1'b0, '0, t0, st);
      load_set(128'h1, 128'h3, 1'b1, 1'b1, set1, t0, st);
      chk("b2b_issue_stall", st, 1);
      @(negedge clk);
      chk("b2b_second_enable", {{(2*N){1'b0}}, enable}, 1);
      @(negedge clk);
      chk("b2b_throughput", en_cyc - prev_en_cyc, 9);
      @(posedge clk);
      #1;

      // Reset mid-load after A0..A3 and B0, with a word offered at the reset edge.
      saved_en = en_count;
      for (int i = 0; i < BEATS + 1; i++)
         send(32'hDEAD_BEEF, 1'b1, acc, st);
      reset    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      reset    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("midrst_busy",     {{(2*N){1'b0}}, busy}, 0);
      chk("midrst_enable",   {{(2*N){1'b0}}, enable}, 0);
      chk("midrst_state",    {{(2*N-1){1'b0}}, dbg_state}, 0);
      chk("midrst_operands", {data_cin, data_in2, data_in1}, 0);
      @(posedge clk);
      #1;
      chk("midrst_no_issue", en_count, saved_en);
      load_set(128'h1, 128'h2, 1'b0, 1'b0, '0, t0, st);
      @(negedge clk);
      chk("midrst_reload_a",   {{(N+1){1'b0}}, data_in1}, 128'h1);
      chk("midrst_reload_b",   {{(N+1){1'b0}}, data_in2}, 128'h2);
      chk("midrst_reload_cin", {{(2*N){1'b0}}, data_cin}, 0);

      // ---------------- final report ----------------
      repeat (5) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      chk("enable_count", en_count, 7);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
